// File: rtl/leading_one_scan.sv
// Multi-cycle leading/trailing one detector: scans one SEG_WD-bit segment per cycle
// from the MSB end (mode 0) or the LSB end (mode 1) and reports the first set bit.
module leading_one_scan #(
  parameter int DATA_WD = 32,
  parameter int SEG_WD  = 8,
  parameter int IND_WD  = $clog2(DATA_WD)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_WD-1:0] i_a,
  input  logic              i_mode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [IND_WD-1:0] o_index,
  output logic              o_found
);

  localparam int NSEG  = DATA_WD / SEG_WD;
  localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int POS_W = (SEG_WD > 1) ? $clog2(SEG_WD) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSEG - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_WD-1:0]   r_a;
  logic                 r_mode;
  logic [IND_WD-1:0]    r_index;
  logic                 r_found;

  logic [CNT_W-1:0]     w_seg_idx;
  logic [SEG_WD-1:0]    w_seg;
  logic [POS_W-1:0]     w_pos;
  logic [IND_WD-1:0]    w_index;
  logic                 w_nz;
  logic                 w_last;

  function automatic logic [POS_W-1:0] msb_pos(input logic [SEG_WD-1:0] seg);
    msb_pos = '0;
    for (int i = 0; i < SEG_WD; i++)
      if (seg[i]) msb_pos = POS_W'(i);
  endfunction

  function automatic logic [POS_W-1:0] lsb_pos(input logic [SEG_WD-1:0] seg);
    lsb_pos = '0;
    for (int i = SEG_WD - 1; i >= 0; i--)
      if (seg[i]) lsb_pos = POS_W'(i);
  endfunction

  // The counter is the scan position; map it to a physical segment per direction.
  assign w_seg_idx = r_mode ? r_cnt : (LAST_CNT - r_cnt);
  assign w_seg     = r_a[int'(w_seg_idx) * SEG_WD +: SEG_WD];
  assign w_pos     = r_mode ? lsb_pos(w_seg) : msb_pos(w_seg);
  assign w_index   = IND_WD'(int'(w_seg_idx) * SEG_WD + int'(w_pos));
  assign w_nz      = |w_seg;
  assign w_last    = (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (w_nz || w_last) w_next = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_mode  <= 1'b0;
      r_index <= '0;
      r_found <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_a    <= i_a;
            r_mode <= i_mode;
            r_cnt  <= '0;
          end
        end
        S_SCAN: begin
          if (w_nz) begin
            r_index <= w_index;
            r_found <= 1'b1;
          end else if (w_last) begin
            r_index <= '0;
            r_found <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_index = r_index;
  assign o_found = r_found;

endmodule

// File: tb/tb_leading_one_scan.sv
// Directed bench for leading_one_scan (32-bit vector, 8-bit segments) with a
// latency/result model checked every cycle plus literal expectations per vector.
module tb_leading_one_scan;

  localparam int DW   = 32;
  localparam int SW   = 8;
  localparam int IW   = 5;
  localparam int NSEG = DW / SW;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_a = '0;
  logic          i_mode = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [IW-1:0] o_index;
  logic          o_found;

  int n_vec = 0;
  int n_err = 0;

  leading_one_scan #(.DATA_WD(DW), .SEG_WD(SW), .IND_WD(IW)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_a    (i_a),
    .i_mode (i_mode),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_index(o_index),
    .o_found(o_found)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first set bit in search direction, latency from its segment position.
  function automatic void ref_scan(input logic [31:0] a, input logic mode,
                                   output int idx, output bit found, output int lat);
    idx = 0; found = 1'b0; lat = NSEG;
    if (mode == 1'b0) begin
      for (int b = 0; b < DW; b++) if (a[b]) begin idx = b; found = 1'b1; end
    end else begin
      for (int b = DW - 1; b >= 0; b--) if (a[b]) begin idx = b; found = 1'b1; end
    end
    if (found) lat = mode ? (idx / SW) + 1 : (NSEG - 1 - idx / SW) + 1;
  endfunction

  bit m_busy = 1'b0, m_done = 1'b0;
  int m_wait = 0, m_pidx = 0, m_index = 0;
  bit m_pfound = 1'b0, m_found = 1'b0;

  always @(posedge i_clk or posedge i_rst) begin
    int  idx, lat;
    bit  fnd;
    if (i_rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_wait <= 0;
      m_index <= 0; m_found <= 1'b0;
    end else if (!m_busy && !m_done) begin
      if (i_valid) begin
        ref_scan(i_a, i_mode, idx, fnd, lat);
        m_busy <= 1'b1; m_wait <= lat - 1; m_pidx <= idx; m_pfound <= fnd;
      end
    end else if (m_busy) begin
      if (m_wait == 0) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_index <= m_pidx; m_found <= m_pfound;
      end else begin
        m_wait <= m_wait - 1;
      end
    end else if (m_done && i_ready) begin
      m_done <= 1'b0;
    end
  end

  always @(negedge i_clk) begin
    chk("model_ready", 32'(o_ready), 32'(!m_busy && !m_done));
    chk("model_valid", 32'(o_valid), 32'(m_done));
    chk("model_index", 32'(o_index), 32'(m_index));
    chk("model_found", 32'(o_found), 32'(m_found));
  end

  task automatic run(input logic [31:0] a, input logic mode, input int hold,
                     input int eidx, input bit efound, input int elat);
    int lat;
    bit got;
    @(posedge i_clk); #2;
    i_a = a; i_mode = mode; i_valid = 1'b1; i_ready = (hold == 0);
    @(posedge i_clk); #2;
    i_valid = 1'b0; i_a = $urandom;
    lat = 0; got = 1'b0;
    for (int c = 0; c < 32 && !got; c++) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_valid) got = 1'b1;
    end
    if (!got) chk("timeout_valid", 32'(o_valid), 32'd1);
    chk("lat_lit", 32'(lat), 32'(elat));
    chk("index_lit", 32'(o_index), 32'(eidx));
    chk("found_lit", 32'(o_found), 32'(efound));
    if (hold > 0) begin
      #1; i_valid = 1'b1; i_a = 32'hFFFF_FFFF; i_mode = ~mode;
      for (int h = 0; h < hold; h++) begin
        @(posedge i_clk); #1;
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_ready", 32'(o_ready), 32'd0);
        chk("hold_index", 32'(o_index), 32'(eidx));
        chk("hold_found", 32'(o_found), 32'(efound));
      end
      #1; i_valid = 1'b0; i_ready = 1'b1;
    end
    @(posedge i_clk); #1;
    chk("back_idle_ready", 32'(o_ready), 32'd1);
    chk("back_idle_valid", 32'(o_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_index", 32'(o_index), 32'd0);
    chk("rst_found", 32'(o_found), 32'd0);
    #1 i_rst = 1'b0;

    run(32'h0001_0000, 1'b0, 0, 16, 1'b1, 2);
    run(32'h0001_0000, 1'b1, 0, 16, 1'b1, 3);
    run(32'h8000_0001, 1'b0, 0, 31, 1'b1, 1);
    run(32'h8000_0001, 1'b1, 0, 0,  1'b1, 1);
    run(32'h0000_0000, 1'b0, 0, 0,  1'b0, 4);
    run(32'h0000_0000, 1'b1, 0, 0,  1'b0, 4);
    run(32'h0000_0100, 1'b1, 5, 8,  1'b1, 2);
    run(32'h0000_8000, 1'b0, 0, 15, 1'b1, 3);
    run(32'h00F0_0000, 1'b1, 0, 20, 1'b1, 3);
    run(32'hFFFF_FFFF, 1'b1, 0, 0,  1'b1, 1);
    run(32'h0000_0009, 1'b0, 0, 3,  1'b1, 4);
    run(32'h0300_0000, 1'b1, 0, 24, 1'b1, 4);

    // Reset during the second scan cycle of a 4-cycle request.
    @(posedge i_clk); #2;
    i_a = 32'h0000_0001; i_mode = 1'b0; i_valid = 1'b1;
    @(posedge i_clk); #2;
    i_valid = 1'b0;
    @(posedge i_clk); #2;
    i_rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_found", 32'(o_found), 32'd0);
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge i_clk); #1;
      chk("post_rst_no_result", 32'(o_valid), 32'd0);
    end
    run(32'h0000_0080, 1'b0, 0, 7, 1'b1, 4);

    repeat (2) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/leading_one_scan.md
LEADING_ONE_SCAN -- requirements
Module: leading_one_scan

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, meaning the input vector width; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter SEG_WD, default 8, meaning the bits examined per scan cycle; it SHALL be a power of two and divide DATA_WD.
REQ-003 SHALL have parameter IND_WD, default $clog2(DATA_WD), meaning the index width.
REQ-004 SHALL define NSEG = DATA_WD/SEG_WD as a derived constant, not as a port parameter.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock. All state SHALL update on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port i_valid, input, 1 bit: the request is valid.
REQ-008 SHALL have port o_ready, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port i_a, input, DATA_WD bits: the vector to scan.
REQ-010 SHALL have port i_mode, input, 1 bit: 0 = leading-one search (MSB first), 1 = trailing-one search (LSB first).
REQ-011 SHALL have port o_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port i_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port o_index, output, IND_WD bits: the bit position of the detected one.
REQ-014 SHALL have port o_found, output, 1 bit: 1 if i_a contained at least one set bit.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, SCAN and DONE.
REQ-016 IDLE SHALL drive o_ready=1 and o_valid=0.
- SCAN SHALL drive o_ready=0 and o_valid=0.
- DONE SHALL drive o_ready=0 and o_valid=1.
REQ-017 A request SHALL be accepted on a rising edge with i_valid=1 in IDLE.
- On acceptance, i_a and i_mode SHALL be captured into internal registers.
- The segment counter SHALL be cleared to 0.
- The FSM SHALL go to SCAN.
REQ-018 While not in IDLE, i_valid, i_a and i_mode SHALL be ignored.
REQ-019 Each SCAN cycle SHALL examine exactly one segment of the captured vector.
- Scan order for mode 0: segment NSEG-1 down to segment 0.
- Scan order for mode 1: segment 0 up to segment NSEG-1.
- Segment s covers bits [s*SEG_WD+SEG_WD-1 : s*SEG_WD].
REQ-020 If the examined segment is nonzero, the block SHALL take these actions on the next edge:
- o_index = s*SEG_WD + p, where p is the highest set bit in the segment (mode 0) or the lowest set bit (mode 1).
- o_found = 1.
- The FSM goes to DONE.
REQ-021 If the examined segment is zero and it is not the last segment in scan order, the counter SHALL increment and the FSM SHALL stay in SCAN.
REQ-022 If the last segment is zero, the block SHALL load o_index=0 and o_found=0 and go to DONE.
REQ-023 Latency SHALL be k+1 cycles from the accept edge to o_valid=1, where k is the 0-based scan position of the first nonzero segment.
- An all-zero vector SHALL take NSEG cycles.
REQ-024 In DONE, o_index and o_found SHALL be registered and held stable until o_valid && i_ready is sampled.
- On that edge the FSM SHALL return to IDLE.
- The next request can be accepted on the following edge at the earliest; there is no back-to-back acceptance.
REQ-025 When NSEG=1, SCAN SHALL last exactly one cycle, and the block SHALL remain correct.
REQ-026 o_index and o_found SHALL be held unchanged outside DONE.
- They are not required to read as zero in that case.
- A consumer SHALL qualify them with o_valid.

Reset
REQ-027 When i_rst is asserted, including mid-SCAN or in DONE, the block SHALL immediately take this state:
- FSM = IDLE.
- Counter = 0.
- Captured data and mode cleared.
- o_index = 0, o_found = 0, o_valid = 0, o_ready = 1.
REQ-028 An in-flight request SHALL be discarded and SHALL NOT produce a result after reset deasserts.
REQ-029 After deassertion, the first acceptance SHALL be possible on the first rising edge with i_valid=1.

Verification
All scenarios use DATA_WD=32 and SEG_WD=8.
REQ-030 Leading search: i_a=0x0001_0000, mode 0, i_ready=1 -> o_valid 2 cycles after accept, o_index=16, o_found=1.
REQ-031 Trailing search, same vector: i_a=0x0001_0000, mode 1 -> o_valid after 3 cycles, o_index=16, o_found=1.
REQ-032 Both ends set: i_a=0x8000_0001 -> mode 0 gives index 31, mode 1 gives index 0, each with o_valid after 1 cycle.
REQ-033 All-zero input: i_a=0, either mode -> o_valid after 4 cycles, o_index=0, o_found=0.
REQ-034 Backpressure: i_a=0x0000_0100, mode 1, i_ready=0 for 5 cycles, then 1.
- Required: o_valid=1, o_index=8 and o_found=1 stay stable throughout.
- Required: o_ready=0, and a new i_valid is ignored.
- Required: return to IDLE one edge after i_ready=1.
REQ-035 Reset mid-scan: accept i_a=0x0000_0001 in mode 0, then assert i_rst during cycle 2.
- Required: o_valid=0 and o_ready=1 immediately.
- Required: no result emitted after release.
- Required: the next request i_a=0x0000_0080 in mode 0 yields index 7 after 4 cycles.
